// File: rtl/pc_target_pipe_pkg.sv
// Shared constants for the pipelined next-PC / branch / JALR target unit.
// Mode encodings and payload layout helpers used by the top and its stage slices.
package pc_target_pipe_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_SEQ   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_PCREL = 2'd1;
  localparam logic [MODE_W-1:0] MODE_JALR  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_RSVD  = 2'd3;

  localparam int DEFAULT_INC = 4;

  // Payload carried through every stage: {tag, illegal, misalign, link, target}.
  function automatic int payload_width(input int width, input int tag_w);
    return 2 * width + 2 + tag_w;
  endfunction

endpackage

// File: rtl/pc_target_stage.sv
// One elastic pipeline slice: a valid bit plus payload register with advance logic.
// Loads when upstream offers data and this slice is empty or draining this cycle.
module pc_target_stage
  import pc_target_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int DATA_W = payload_width(WIDTH, TAG_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              w_advance;
  logic              w_load;

  assign w_advance = r_valid && i_ready;
  assign w_load    = i_valid && (!r_valid || i_ready);

  // NOTE: sequential state uses non-blocking assignments so every slice samples
  // its neighbour's pre-edge value; blocking here would collapse the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
    end else if (w_advance) begin
      r_valid <= 1'b0;
    end
  end

  // Payload only moves on load, so a stalled slice holds its outputs stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (w_load) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pc_target_pipe.sv
// Elastic pipelined PC target / link adder for EX-stage branch resolution.
// Stage 1 registers the combinational adder result; later stages pass it through.
module pc_target_pipe
  import pc_target_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int INC    = DEFAULT_INC,
  parameter int TAG_W  = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [MODE_W-1:0] IN_MODE,
  input  logic [WIDTH-1:0]  IN_PC,
  input  logic [WIDTH-1:0]  IN_IMM,
  input  logic [WIDTH-1:0]  IN_BASE,
  input  logic [TAG_W-1:0]  IN_TAG,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [WIDTH-1:0]  OUT_TARGET,
  output logic [WIDTH-1:0]  OUT_LINK,
  output logic              OUT_MISALIGN,
  output logic              OUT_ILLEGAL,
  output logic [TAG_W-1:0]  OUT_TAG
);

  localparam int DATA_W = payload_width(WIDTH, TAG_W);

  logic [WIDTH-1:0]  w_link;
  logic [WIDTH-1:0]  w_pc_imm;
  logic [WIDTH-1:0]  w_base_imm;
  logic [WIDTH-1:0]  w_target;
  logic              w_illegal;
  logic              w_misalign;

  logic [STAGES:0]   w_valid;
  logic [STAGES:0]   w_ready;
  logic [DATA_W-1:0] w_data [0:STAGES];

  assign w_link     = IN_PC + WIDTH'(INC);
  assign w_pc_imm   = IN_PC + IN_IMM;
  assign w_base_imm = IN_BASE + IN_IMM;

  always_comb begin
    w_target  = w_link;
    w_illegal = 1'b0;
    case (IN_MODE)
      MODE_SEQ:   w_target = w_link;
      MODE_PCREL: w_target = w_pc_imm;
      MODE_JALR:  w_target = w_base_imm & ~WIDTH'(1);
      default: begin
        w_target  = w_link;
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_misalign = |w_target[1:0];

  assign w_valid[0] = IN_VALID;
  assign w_data[0]  = {IN_TAG, w_illegal, w_misalign, w_link, w_target};

  // Ready ripples backward in one block: slice k accepts when empty or its successor accepts.
  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = OUT_READY;
    for (int k = STAGES; k >= 1; k--) begin
      w_ready[k-1] = !w_valid[k] || w_ready[k];
    end
  end

  assign IN_READY = w_ready[0];

  for (genvar g = 1; g <= STAGES; g++) begin : g_stage
    pc_target_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk     (CLK),
      .rst     (RESET),
      .i_flush (FLUSH),
      .i_valid (w_valid[g-1]),
      .i_ready (w_ready[g]),
      .i_data  (w_data[g-1]),
      .o_valid (w_valid[g]),
      .o_data  (w_data[g])
    );
  end

  assign OUT_VALID    = w_valid[STAGES];
  assign OUT_TARGET   = w_data[STAGES][WIDTH-1:0];
  assign OUT_LINK     = w_data[STAGES][2*WIDTH-1:WIDTH];
  assign OUT_MISALIGN = w_data[STAGES][2*WIDTH];
  assign OUT_ILLEGAL  = w_data[STAGES][2*WIDTH+1];
  assign OUT_TAG      = w_data[STAGES][2*WIDTH+2 +: TAG_W];

endmodule
